// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with selectable FWFT or registered read, programmable almost-full/almost-empty
// flags, an occupancy count and sticky overflow/underflow error flags.
module sync_fifo_ext #(
    parameter int FF_DEPTH  = 16,
    parameter int FF_WIDTH  = 8,
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = FF_DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wren,
    input  logic [FF_WIDTH-1:0]       din,
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rden,
    output logic [FF_WIDTH-1:0]       dout,
    output logic                      valid,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [$clog2(FF_DEPTH):0] count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr
);
    localparam int AW = $clog2(FF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FF_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [FF_WIDTH-1:0] mem [FF_DEPTH];
    logic [CW-1:0]       wrptr;
    logic [CW-1:0]       rdptr;
    logic                rd_acc;
    logic                wr_acc;

    // Pointers carry one extra wrap bit, so the difference is the exact occupancy 0..FF_DEPTH.
    assign count        = wrptr - rdptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign rd_acc = rden & ~empty;
    assign wr_acc = wren & (~full | rd_acc);

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wrptr[AW-1:0]] <= din;
        end
    end

    // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            if (wr_acc) wrptr <= wrptr + CW'(1);
            if (rd_acc) rdptr <= rdptr + CW'(1);
        end
    end

    // A new error event in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren && !wr_acc) overflow <= 1'b1;
            else if (err_clr)    overflow <= 1'b0;
            if (rden && empty)   underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout  = mem[rdptr[AW-1:0]];
            assign valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout  <= '0;
                    valid <= 1'b0;
                end else begin
                    valid <= rd_acc;
                    if (rd_acc) dout <= mem[rdptr[AW-1:0]];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: four instances (depth 4/8, registered/FWFT) share one stimulus
// set; each task checks the instance its scenario targets.
module tb_sync_fifo_ext;
    logic       clk = 1'b0;
    logic       rst, wren, rden, err_clr;
    logic [7:0] din;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // a: depth 4 registered, AFULL_TH 3   b: depth 4 FWFT
    // c: depth 8 registered               d: depth 8 FWFT
    logic       a_full, a_af, a_empty, a_ae, a_valid, a_ovf, a_unf;
    logic [7:0] a_dout;
    logic [2:0] a_count;
    logic       b_full, b_af, b_empty, b_ae, b_valid, b_ovf, b_unf;
    logic [7:0] b_dout;
    logic [2:0] b_count;
    logic       c_full, c_af, c_empty, c_ae, c_valid, c_ovf, c_unf;
    logic [7:0] c_dout;
    logic [3:0] c_count;
    logic       d_full, d_af, d_empty, d_ae, d_valid, d_ovf, d_unf;
    logic [7:0] d_dout;
    logic [3:0] d_count;

    sync_fifo_ext #(.FF_DEPTH(4), .FF_WIDTH(8), .FWFT(1'b0), .AFULL_TH(3), .AEMPTY_TH(2)) u_a (
        .clk(clk), .rst(rst), .wren(wren), .din(din), .full(a_full), .almost_full(a_af),
        .rden(rden), .dout(a_dout), .valid(a_valid), .empty(a_empty), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf), .err_clr(err_clr));

    sync_fifo_ext #(.FF_DEPTH(4), .FF_WIDTH(8), .FWFT(1'b1)) u_b (
        .clk(clk), .rst(rst), .wren(wren), .din(din), .full(b_full), .almost_full(b_af),
        .rden(rden), .dout(b_dout), .valid(b_valid), .empty(b_empty), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf), .err_clr(err_clr));

    sync_fifo_ext #(.FF_DEPTH(8), .FF_WIDTH(8), .FWFT(1'b0)) u_c (
        .clk(clk), .rst(rst), .wren(wren), .din(din), .full(c_full), .almost_full(c_af),
        .rden(rden), .dout(c_dout), .valid(c_valid), .empty(c_empty), .almost_empty(c_ae),
        .count(c_count), .overflow(c_ovf), .underflow(c_unf), .err_clr(err_clr));

    sync_fifo_ext #(.FF_DEPTH(8), .FF_WIDTH(8), .FWFT(1'b1)) u_d (
        .clk(clk), .rst(rst), .wren(wren), .din(din), .full(d_full), .almost_full(d_af),
        .rden(rden), .dout(d_dout), .valid(d_valid), .empty(d_empty), .almost_empty(d_ae),
        .count(d_count), .overflow(d_ovf), .underflow(d_unf), .err_clr(err_clr));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1; wren = 1'b1; rden = 1'b1; din = 8'hFF; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0; wren = 1'b0; rden = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({a_count, a_empty, a_ae, a_full, a_af, a_valid, a_ovf, a_unf} !== {3'd0, 7'b1100000}) begin
            failures++;
            $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b v=%b ovf=%b unf=%b, need cnt=0 e=1 ae=1 others 0",
                     a_count, a_empty, a_ae, a_full, a_af, a_valid, a_ovf, a_unf);
        end
        checks++;
        if (a_dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout: got %h need 00", a_dout);
        end
        checks++;
        if ({b_count, b_valid, c_count, d_count} !== 12'd0) begin
            failures++;
            $display("FAIL reset_other: b_cnt=%0d b_v=%b c_cnt=%0d d_cnt=%0d need all 0",
                     b_count, b_valid, c_count, d_count);
        end
    endtask

    task automatic test_fill_overflow;
        logic [7:0] wdata [5];
        logic [2:0] exp_cnt [5];
        logic [2:0] exp_flags [5];  // {almost_full, full, overflow}
        wdata     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_cnt   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_flags = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b111};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1; din = wdata[i];
            tick();
            checks++;
            if ({a_count, a_af, a_full, a_ovf} !== {exp_cnt[i], exp_flags[i]}) begin
                failures++;
                $display("FAIL fill_write%0d: got cnt=%0d af=%b f=%b ovf=%b need cnt=%0d af/f/ovf=%b",
                         i, a_count, a_af, a_full, a_ovf, exp_cnt[i], exp_flags[i]);
            end
        end
        wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rden = 1'b1;
            tick();
            checks++;
            if ({a_valid, a_dout, a_count} !== {1'b1, wdata[i], 3'(3 - i)}) begin
                failures++;
                $display("FAIL fill_read%0d: got v=%b dout=%h cnt=%0d need v=1 dout=%h cnt=%0d",
                         i, a_valid, a_dout, a_count, wdata[i], 3 - i);
            end
        end
        rden = 1'b0;
        tick();
        checks++;
        if ({a_valid, a_dout, a_empty, a_ovf} !== {1'b0, 8'h44, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL fill_idle: got v=%b dout=%h e=%b ovf=%b need v=0 dout=44 e=1 ovf=1",
                     a_valid, a_dout, a_empty, a_ovf);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b need 0", a_ovf);
        end
    endtask

    task automatic test_full_rw;
        logic [7:0] drain [4];
        drain = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1; din = 8'hA0 + 8'(i);
            tick();
        end
        din = 8'hB0; rden = 1'b1;
        tick();
        wren = 1'b0;
        checks++;
        if ({a_valid, a_dout, a_count, a_full, a_ovf} !== {1'b1, 8'hA0, 3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL full_rw: got v=%b dout=%h cnt=%0d f=%b ovf=%b need v=1 dout=a0 cnt=4 f=1 ovf=0",
                     a_valid, a_dout, a_count, a_full, a_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({a_valid, a_dout} !== {1'b1, drain[i]}) begin
                failures++;
                $display("FAIL full_rw_drain%0d: got v=%b dout=%h need v=1 dout=%h", i, a_valid, a_dout, drain[i]);
            end
        end
        rden = 1'b0;
        tick();
    endtask

    task automatic test_underflow;
        apply_reset();
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if ({a_unf, a_count, a_valid} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL underflow_set: got unf=%b cnt=%0d v=%b need unf=1 cnt=0 v=0", a_unf, a_count, a_valid);
        end
        err_clr = 1'b1;
        tick();
        checks++;
        if (a_unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: got %b need 0", a_unf);
        end
        rden = 1'b1;
        tick();
        rden = 1'b0; err_clr = 1'b0;
        checks++;
        if (a_unf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set_wins: got %b need 1", a_unf);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        // read and write together on an empty FIFO: write lands, read is refused
        wren = 1'b1; rden = 1'b1; din = 8'hC3;
        tick();
        wren = 1'b0; rden = 1'b0;
        checks++;
        if ({a_count, a_unf, a_valid, a_ovf} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL empty_rw: got cnt=%0d unf=%b v=%b ovf=%b need cnt=1 unf=1 v=0 ovf=0",
                     a_count, a_unf, a_valid, a_ovf);
        end
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if ({a_valid, a_dout} !== {1'b1, 8'hC3}) begin
            failures++;
            $display("FAIL empty_rw_read: got v=%b dout=%h need v=1 dout=c3", a_valid, a_dout);
        end
    endtask

    task automatic test_fwft;
        apply_reset();
        wren = 1'b1; din = 8'h5A;
        tick();
        wren = 1'b0;
        checks++;
        if ({b_valid, b_dout} !== {1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL fwft_first: got v=%b dout=%h need v=1 dout=5a", b_valid, b_dout);
        end
        wren = 1'b1; din = 8'h6B;
        tick();
        wren = 1'b0;
        checks++;
        if ({b_dout, b_count} !== {8'h5A, 3'd2}) begin
            failures++;
            $display("FAIL fwft_hold: got dout=%h cnt=%0d need dout=5a cnt=2", b_dout, b_count);
        end
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if ({b_valid, b_dout} !== {1'b1, 8'h6B}) begin
            failures++;
            $display("FAIL fwft_pop: got v=%b dout=%h need v=1 dout=6b", b_valid, b_dout);
        end
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if ({b_valid, b_empty, b_unf} !== 3'b010) begin
            failures++;
            $display("FAIL fwft_empty: got v=%b e=%b unf=%b need v=0 e=1 unf=0", b_valid, b_empty, b_unf);
        end
    endtask

    task automatic test_soak;
        logic [7:0] q [$];
        logic [7:0] next_data = 8'h00;
        logic [7:0] exp_dout  = 8'h00;
        logic       exp_v;
        int         sz;
        int         wp, rp;
        apply_reset();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            wp = (cyc < 500) ? 70 : 30;
            rp = (cyc < 500) ? 40 : 70;
            wren = ($urandom_range(0, 99) < wp) && (q.size() < 8);
            rden = ($urandom_range(0, 99) < rp) && (q.size() > 0);
            din  = next_data;
            tick();
            exp_v = rden;
            if (rden) exp_dout = q.pop_front();
            if (wren) begin
                q.push_back(din);
                next_data = next_data + 8'd1;
            end
            sz = q.size();
            checks++;
            if ({c_count, c_full, c_empty, c_af, c_ae, c_ovf, c_unf} !==
                {4'(sz), sz == 8, sz == 0, sz >= 6, sz <= 2, 2'b00}) begin
                failures++;
                $display("FAIL soak_flags_reg cyc%0d: got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b unf=%b need cnt=%0d",
                         cyc, c_count, c_full, c_empty, c_af, c_ae, c_ovf, c_unf, sz);
            end
            checks++;
            if (c_valid !== exp_v || (exp_v && c_dout !== exp_dout)) begin
                failures++;
                $display("FAIL soak_data_reg cyc%0d: got v=%b dout=%h need v=%b dout=%h",
                         cyc, c_valid, c_dout, exp_v, exp_dout);
            end
            checks++;
            if ({d_count, d_valid, d_ovf, d_unf} !== {4'(sz), sz != 0, 2'b00}) begin
                failures++;
                $display("FAIL soak_flags_fwft cyc%0d: got cnt=%0d v=%b ovf=%b unf=%b need cnt=%0d v=%b",
                         cyc, d_count, d_valid, d_ovf, d_unf, sz, sz != 0);
            end
            if (sz != 0) begin
                checks++;
                if (d_dout !== q[0]) begin
                    failures++;
                    $display("FAIL soak_data_fwft cyc%0d: got dout=%h need %h", cyc, d_dout, q[0]);
                end
            end
        end
        wren = 1'b0;
        rden = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; din = 8'h00;
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_fwft();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
